driver_sout_reader: RTL and testbench

- Read-back receiver for the LED-driver serial chain. It captures each driver's SOUT stream while driver_controller shifts data on SIN/SCLK.
- Steps the 5-bit SOUT mux across all drivers and compares the captured word with the expected serialized configuration.
- Reports a per-driver mismatch/timeout mask to the SoM/debug logic.
- Sits beside driver_controller: it observes driver_sclk and owns driver_sout_mux.

---
 rtl/driver_sout_reader_if.sv | 28 ++
 rtl/driver_sout_reader.sv | 175 +++++++++++++++++
 tb/tb_driver_sout_reader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/driver_sout_reader_if.sv
// Bus between the SOUT read-back receiver and its controlling/observing logic.
// The master side drives sweep control and the driver serial lines; the slave side is the reader.
interface driver_sout_reader_if #(
  parameter int NB_DRIVERS = 30,
  parameter int DATA_WIDTH = 48
);
  logic                  start;
  logic                  abort;
  logic [DATA_WIDTH-1:0] expected;
  logic                  driver_sclk;
  logic                  driver_sout;
  logic [4:0]            driver_sout_mux;
  logic                  busy;
  logic                  done;
  logic [NB_DRIVERS-1:0] error_mask;
  logic [NB_DRIVERS-1:0] timeout_mask;
  logic [DATA_WIDTH-1:0] last_word;

  modport master (
    output start, abort, expected, driver_sclk, driver_sout,
    input  driver_sout_mux, busy, done, error_mask, timeout_mask, last_word
  );

  modport slave (
    input  start, abort, expected, driver_sclk, driver_sout,
    output driver_sout_mux, busy, done, error_mask, timeout_mask, last_word
  );
endinterface

// File: rtl/driver_sout_reader.sv
// Steps the SOUT mux over every LED driver, captures each SOUT word on SCLK rising edges
// and flags drivers whose read-back differs from the expected word or never clocks.
//
// state   | meaning
// IDLE    | waiting for start
// SELECT  | drive mux with current index, load settle counter
// SETTLE  | wait for the mux output to settle, sclk edges ignored
// SHIFT   | capture DATA_WIDTH bits MSB-first, watch for timeout
// COMPARE | store captured word, flag mismatch
// NEXT    | advance index or finish the sweep
module driver_sout_reader #(
  parameter int NB_DRIVERS     = 30,
  parameter int DATA_WIDTH     = 48,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                  clk,
  input logic                  nrst,
  driver_sout_reader_if.slave  bus
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);
  localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    IDX_LAST    = 5'(NB_DRIVERS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETTLE, S_SHIFT, S_COMPARE, S_NEXT
  } state_t;

  state_t                state_q, state_d;
  logic [4:0]            idx_q, idx_d;
  logic [4:0]            mux_q, mux_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic [NB_DRIVERS-1:0] err_q, err_d;
  logic [NB_DRIVERS-1:0] tmask_q, tmask_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  sclk_q;
  logic                  sclk_rise;

  assign sclk_rise = bus.driver_sclk & ~sclk_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      mux_q    <= '0;
      settle_q <= '0;
      bit_q    <= '0;
      tmo_q    <= '0;
      shift_q  <= '0;
      exp_q    <= '0;
      last_q   <= '0;
      err_q    <= '0;
      tmask_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mux_q    <= mux_d;
      settle_q <= settle_d;
      bit_q    <= bit_d;
      tmo_q    <= tmo_d;
      shift_q  <= shift_d;
      exp_q    <= exp_d;
      last_q   <= last_d;
      err_q    <= err_d;
      tmask_q  <= tmask_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sclk_q   <= bus.driver_sclk;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mux_d    = mux_q;
    settle_d = settle_q;
    bit_d    = bit_q;
    tmo_d    = tmo_q;
    shift_d  = shift_q;
    exp_d    = exp_q;
    last_d   = last_q;
    err_d    = err_q;
    tmask_d  = tmask_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    // Abort overrides everything, including a simultaneous start; masks and mux are kept.
    if (bus.abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            exp_d   = bus.expected;
            err_d   = '0;
            tmask_d = '0;
            idx_d   = '0;
            busy_d  = 1'b1;
            state_d = S_SELECT;
          end
        end
        S_SELECT: begin
          mux_d    = idx_q;
          settle_d = SETTLE_LOAD;
          state_d  = S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_q <= SW'(1)) begin
            bit_d   = '0;
            shift_d = '0;
            tmo_d   = '0;
            state_d = S_SHIFT;
          end else begin
            settle_d = settle_q - SW'(1);
          end
        end
        S_SHIFT: begin
          // An edge on the threshold cycle still counts and restarts the timeout.
          if (sclk_rise) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], bus.driver_sout};
            bit_d   = bit_q + BW'(1);
            tmo_d   = '0;
            if (bit_q == BIT_LAST) state_d = S_COMPARE;
          end else if (tmo_q == TMO_LAST) begin
            tmask_d[idx_q] = 1'b1;
            err_d[idx_q]   = 1'b1;
            state_d        = S_NEXT;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        S_COMPARE: begin
          last_d       = shift_q;
          err_d[idx_q] = (shift_q != exp_q);
          state_d      = S_NEXT;
        end
        S_NEXT: begin
          if (idx_q == IDX_LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_SELECT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.driver_sout_mux = mux_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.error_mask      = err_q;
  assign bus.timeout_mask    = tmask_q;
  assign bus.last_word       = last_q;

endmodule

// File: tb/tb_driver_sout_reader.sv
// Directed bench for driver_sout_reader: models the driver chain answering on SOUT
// per mux index and checks sweep results against hand-computed masks and words.
module tb_driver_sout_reader;
  localparam int NB  = 30;
  localparam int DW  = 48;
  localparam int TMO = 200;

  logic clk;
  logic nrst;
  int   n_chk;
  int   n_pass;
  int   done_total;

  driver_sout_reader_if #(.NB_DRIVERS(NB), .DATA_WIDTH(DW)) bus ();

  driver_sout_reader #(
    .NB_DRIVERS(NB), .DATA_WIDTH(DW), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.done) done_total <= done_total + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic pulse_start(input logic [DW-1:0] w);
    bus.expected = w;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.expected = ~w;
  endtask

  task automatic burst(input int n, input logic [DW-1:0] w);
    for (int b = 0; b < n; b++) begin
      bus.driver_sclk = 1'b0;
      bus.driver_sout = w[DW-1-b];
      repeat (2) @(negedge clk);
      bus.driver_sclk = 1'b1;
      repeat (2) @(negedge clk);
    end
    bus.driver_sclk = 1'b0;
  endtask

  task automatic wait_mux(input int idx, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (bus.driver_sout_mux == 5'(idx)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_sweep(input logic [DW-1:0] w, input int bad_idx, input int tmo_idx,
                           input int abort_idx, input bit settle_edge, input bit busy_start);
    int d0;
    bit ok;
    d0 = done_total;
    pulse_start(w);
    for (int i = 0; i < NB; i++) begin
      if (i > 0) begin
        wait_mux(i, ok);
        if (!ok) begin
          check("mux_step", 64'(bus.driver_sout_mux), 64'(i));
          return;
        end
        if (settle_edge) begin
          bus.driver_sclk = 1'b1;
          @(negedge clk);
          bus.driver_sclk = 1'b0;
        end
      end
      repeat (8) @(negedge clk);
      if (i == tmo_idx) continue;
      if (i == abort_idx) begin
        burst(10, w);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        repeat (300) @(negedge clk);
        check("abort_no_done", 64'(done_total - d0), 64'd0);
        check("abort_still_idle", 64'(bus.busy), 64'd0);
        check("abort_mux_hold", 64'(bus.driver_sout_mux), 64'(abort_idx));
        return;
      end
      if (busy_start && i == 5) begin
        check("busy_mid_sweep", 64'(bus.busy), 64'd1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
      burst(DW, (i == bad_idx) ? (w ^ 48'h1) : w);
    end
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("sweep_end", 64'(ok), 64'd1);
    check("done_pulse", 64'(bus.done), 64'd1);
    check("final_mux", 64'(bus.driver_sout_mux), 64'(NB - 1));
    @(negedge clk);
    check("done_once", 64'(done_total - d0), 64'd1);
    check("done_low", 64'(bus.done), 64'd0);
  endtask

  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  bit            idle_bad;

  initial begin
    n_chk = 0;
    n_pass = 0;
    w_a = 48'hA5A5_0F0F_1234;
    w_b = 48'h8000_0000_0001;
    nrst = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.expected = '0;
    bus.driver_sclk = 1'b0;
    bus.driver_sout = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;

    idle_bad = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.driver_sout_mux != 0 || bus.busy || bus.done || bus.error_mask != 0 ||
          bus.timeout_mask != 0 || bus.last_word != 0) idle_bad = 1'b1;
    end
    check("idle_quiet", 64'(idle_bad), 64'd0);
    check("reset_mux", 64'(bus.driver_sout_mux), 64'd0);
    check("reset_last_word", 64'(bus.last_word), 64'd0);

    run_sweep(w_a, -1, -1, -1, 1'b0, 1'b0);
    check("match_err", 64'(bus.error_mask), 64'd0);
    check("match_tmo", 64'(bus.timeout_mask), 64'd0);
    check("match_word", 64'(bus.last_word), 64'hA5A5_0F0F_1234);

    run_sweep(w_a, 7, -1, -1, 1'b0, 1'b0);
    check("fault_err", 64'(bus.error_mask), 64'h0000_0080);
    check("fault_tmo", 64'(bus.timeout_mask), 64'd0);
    check("fault_word", 64'(bus.last_word), 64'hA5A5_0F0F_1234);

    run_sweep(w_a, -1, 3, -1, 1'b0, 1'b0);
    check("tmo_err", 64'(bus.error_mask), 64'h0000_0008);
    check("tmo_tmo", 64'(bus.timeout_mask), 64'h0000_0008);

    run_sweep(w_a, -1, -1, 12, 1'b0, 1'b0);
    check("abort_err_partial", 64'(bus.error_mask), 64'd0);

    run_sweep(w_b, -1, -1, -1, 1'b1, 1'b1);
    check("restart_err", 64'(bus.error_mask), 64'd0);
    check("restart_tmo", 64'(bus.timeout_mask), 64'd0);
    check("restart_word", 64'(bus.last_word), 64'h8000_0000_0001);

    pulse_start(w_a);
    repeat (5) @(negedge clk);
    check("pre_reset_busy", 64'(bus.busy), 64'd1);
    #2 nrst = 1'b0;
    #1;
    check("async_busy", 64'(bus.busy), 64'd0);
    check("async_mux", 64'(bus.driver_sout_mux), 64'd0);
    check("async_word", 64'(bus.last_word), 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_idle", 64'(bus.busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
